// File: rtl/memgame_pkg.sv
// memgame_pkg -- shared definitions for the memory game core.
//   state_e    : game FSM states
//   LFSR_W     : width of the pattern LFSR
//   LFSR_SEED  : LFSR value after reset
//   LFSR_TAPS  : feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
package memgame_pkg;

  localparam int         LFSR_W    = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INTRO    = 4'd1,
    ST_SHOW_ON  = 4'd2,
    ST_SHOW_OFF = 4'd3,
    ST_INPUT    = 4'd4,
    ST_CHECK    = 4'd5,
    ST_LEVEL_UP = 4'd6,
    ST_WIN      = 4'd7,
    ST_LOSE     = 4'd8
  } state_e;

endpackage

// File: rtl/memgame_lfsr.sv
// memgame_lfsr -- 8-bit Fibonacci LFSR, maximal length, shifts towards the MSB.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, loads LFSR_SEED
//   i_en    : advance one step when high
//   o_state : current LFSR contents
module memgame_lfsr
  import memgame_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb    = ^(r_lfsr & LFSR_TAPS);
  assign o_state = r_lfsr;

  // LFSR shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/memory_game_core.sv
// memory_game_core -- "repeat the colour sequence" game controller.
// Ports:
//   clk              : sole clock, rising edge
//   reset            : asynchronous active-low reset (release synchronised internally)
//   Go, LBtn, RBtn   : single-cycle pulses: confirm, cursor left, cursor right
//   Color            : one-hot LED drive (all ones during intro flashes)
//   SendColor        : high whenever Color is non-zero
//   Level, Score     : current pattern length / levels cleared
//   Win, Lose        : high while in WIN / LOSE
// Configuration macro: MEMGAME_TIMEOUT_EN -- when defined, TIMEOUT_CYCLES idle
// INPUT cycles lose the game; otherwise INPUT waits forever.
module memory_game_core
  import memgame_pkg::*;
#(
  parameter int NUM_COLORS     = 5,
  parameter int MAX_LEVEL      = 16,
  parameter int SHOW_CYCLES    = 1000,
  parameter int INTRO_FLASHES  = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Go,
  input  logic                           LBtn,
  input  logic                           RBtn,
  output logic [NUM_COLORS-1:0]          Color,
  output logic                           SendColor,
  output logic [$clog2(MAX_LEVEL+1)-1:0] Level,
  output logic [$clog2(MAX_LEVEL+1)-1:0] Score,
  output logic                           Win,
  output logic                           Lose
);

  localparam int CW = $clog2(NUM_COLORS);
  localparam int LW = $clog2(MAX_LEVEL+1);
  localparam int IW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int TW = $clog2(SHOW_CYCLES);
  localparam int FW = (INTRO_FLASHES > 1) ? $clog2(INTRO_FLASHES) : 1;

  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(SHOW_CYCLES / 2 - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(INTRO_FLASHES - 1);
  localparam logic [IW-1:0] FILL_LAST  = IW'(MAX_LEVEL - 1);
  localparam logic [CW-1:0] CUR_LAST   = CW'(NUM_COLORS - 1);
  localparam logic [LW-1:0] LVL_MAX    = LW'(MAX_LEVEL);

  function automatic logic [NUM_COLORS-1:0] onehot(input logic [CW-1:0] idx);
    return {{(NUM_COLORS-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [LFSR_W-1:0]     w_lfsr;
  logic [CW-1:0]         w_rand;
  logic [CW-1:0]         r_pat [2**IW];

  state_e                r_state, w_state_nxt;
  logic                  r_filling, w_filling_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;
  logic                  r_phase, w_phase_nxt;   // intro: 0 = LEDs on, 1 = LEDs off
  logic [FW-1:0]         r_flash, w_flash_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;       // fill / replay / input index
  logic [CW-1:0]         r_cursor, w_cursor_nxt;
  logic [LW-1:0]         r_level, w_level_nxt;
  logic [LW-1:0]         r_score, w_score_nxt;
  logic [NUM_COLORS-1:0] r_color, w_color_nxt;
  logic                  r_send, r_win, r_lose;
  logic                  w_pat_we, w_tmo_hit, w_idx_last;

  // Assert asynchronously, release two clocks later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  memgame_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_rand     = CW'(w_lfsr % LFSR_W'(NUM_COLORS));
  assign w_idx_last = (LW'(r_idx) == (r_level - LW'(1)));

  // Pattern store, written only while filling; survives reset
  always_ff @(posedge clk) begin
    if (w_pat_we) begin
      r_pat[r_idx] <= w_rand;
    end
  end

`ifdef MEMGAME_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] r_tmo;

  // Idle-cycle counter, cleared by any button pulse or by leaving INPUT
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tmo <= {TOW{1'b0}};
    end else if ((r_state != ST_INPUT) || Go || LBtn || RBtn) begin
      r_tmo <= {TOW{1'b0}};
    end else begin
      r_tmo <= r_tmo + TOW'(1);
    end
  end
  assign w_tmo_hit = (r_state == ST_INPUT) && (r_tmo == TOW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state and counter logic
  always_comb begin
    w_state_nxt   = r_state;
    w_filling_nxt = r_filling;
    w_timer_nxt   = r_timer;
    w_phase_nxt   = r_phase;
    w_flash_nxt   = r_flash;
    w_idx_nxt     = r_idx;
    w_cursor_nxt  = r_cursor;
    w_level_nxt   = r_level;
    w_score_nxt   = r_score;
    w_pat_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_filling) begin
          w_pat_we = 1'b1;
          if (r_idx == FILL_LAST) begin
            w_filling_nxt = 1'b0;
            w_state_nxt   = ST_INTRO;
            w_timer_nxt   = {TW{1'b0}};
            w_phase_nxt   = 1'b0;
            w_flash_nxt   = {FW{1'b0}};
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else if (Go) begin
          w_filling_nxt = 1'b1;
          w_idx_nxt     = {IW{1'b0}};
          w_level_nxt   = {LW{1'b0}};
          w_score_nxt   = {LW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INTRO: begin
        if (r_timer == SHOW_LAST) begin
          w_timer_nxt = {TW{1'b0}};
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else if (r_flash == FLASH_LAST) begin
            w_state_nxt = ST_SHOW_ON;
            w_phase_nxt = 1'b0;
            w_idx_nxt   = {IW{1'b0}};
            w_level_nxt = LW'(1);
            w_score_nxt = {LW{1'b0}};
          end else begin
            w_phase_nxt = 1'b0;
            w_flash_nxt = r_flash + FW'(1);
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_SHOW_ON: begin
        if (r_timer == SHOW_LAST) begin
          w_timer_nxt = {TW{1'b0}};
          w_state_nxt = ST_SHOW_OFF;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (r_timer == GAP_LAST) begin
          w_timer_nxt = {TW{1'b0}};
          if (w_idx_last) begin
            w_state_nxt  = ST_INPUT;
            w_idx_nxt    = {IW{1'b0}};
            w_cursor_nxt = {CW{1'b0}};
          end else begin
            w_state_nxt = ST_SHOW_ON;
            w_idx_nxt   = r_idx + IW'(1);
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_INPUT: begin
        // Go wins over the cursor buttons; L+R together cancel out
        if (Go) begin
          w_state_nxt = ST_CHECK;
        end else if (RBtn && !LBtn) begin
          w_cursor_nxt = (r_cursor == CUR_LAST) ? {CW{1'b0}} : r_cursor + CW'(1);
        end else if (LBtn && !RBtn) begin
          w_cursor_nxt = (r_cursor == {CW{1'b0}}) ? CUR_LAST : r_cursor - CW'(1);
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_LOSE;
        end else begin
          w_state_nxt = ST_INPUT;
        end
      end
      ST_CHECK: begin
        if (r_cursor != r_pat[r_idx]) begin
          w_state_nxt = ST_LOSE;
        end else if (w_idx_last) begin
          w_state_nxt = ST_LEVEL_UP;
        end else begin
          w_state_nxt = ST_INPUT;
          w_idx_nxt   = r_idx + IW'(1);
        end
      end
      ST_LEVEL_UP: begin
        w_score_nxt = r_score + LW'(1);
        if (r_level == LVL_MAX) begin
          w_state_nxt = ST_WIN;
        end else begin
          w_state_nxt = ST_SHOW_ON;
          w_level_nxt = r_level + LW'(1);
          w_idx_nxt   = {IW{1'b0}};
          w_timer_nxt = {TW{1'b0}};
        end
      end
      ST_WIN, ST_LOSE: begin
        if (Go) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // LED pattern for the upcoming state, so Color is a registered output
  always_comb begin
    w_color_nxt = {NUM_COLORS{1'b0}};
    case (w_state_nxt)
      ST_INTRO: begin
        if (!w_phase_nxt) begin
          w_color_nxt = {NUM_COLORS{1'b1}};
        end else begin
          w_color_nxt = {NUM_COLORS{1'b0}};
        end
      end
      ST_SHOW_ON:        w_color_nxt = onehot(r_pat[w_idx_nxt]);
      ST_INPUT, ST_CHECK: w_color_nxt = onehot(w_cursor_nxt);
      default:           w_color_nxt = {NUM_COLORS{1'b0}};
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_filling <= 1'b0;
      r_timer   <= {TW{1'b0}};
      r_phase   <= 1'b0;
      r_flash   <= {FW{1'b0}};
      r_idx     <= {IW{1'b0}};
      r_cursor  <= {CW{1'b0}};
      r_level   <= {LW{1'b0}};
      r_score   <= {LW{1'b0}};
      r_color   <= {NUM_COLORS{1'b0}};
      r_send    <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_filling <= w_filling_nxt;
      r_timer   <= w_timer_nxt;
      r_phase   <= w_phase_nxt;
      r_flash   <= w_flash_nxt;
      r_idx     <= w_idx_nxt;
      r_cursor  <= w_cursor_nxt;
      r_level   <= w_level_nxt;
      r_score   <= w_score_nxt;
      r_color   <= w_color_nxt;
      r_send    <= |w_color_nxt;
      r_win     <= (w_state_nxt == ST_WIN);
      r_lose    <= (w_state_nxt == ST_LOSE);
    end
  end

  assign Color     = r_color;
  assign SendColor = r_send;
  assign Level     = r_level;
  assign Score     = r_score;
  assign Win       = r_win;
  assign Lose      = r_lose;

endmodule

// File: tb/tb_memory_game_core.sv
// tb_memory_game_core -- randomized self-checking bench for memory_game_core.
// The reference model predicts the pattern from the LFSR polynomial and the
// cycle on which Go is accepted, then builds the expected LED stream per level.
// Define MEMGAME_TIMEOUT_EN to also exercise the input timeout (TIMEOUT_CYCLES=10).
module tb_memory_game_core;

  localparam int NC  = 5;
  localparam int ML  = 2;
  localparam int SC  = 4;
  localparam int IFL = 1;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Go = 1'b0, LBtn = 1'b0, RBtn = 1'b0;
  logic [NC-1:0] Color;
  logic          SendColor;
  logic [1:0]    Level, Score;
  logic          Win, Lose;

  int            total = 0;
  int            bad = 0;
  int            edges = 0;
  int            cur = 0;
  int            pat [ML];

  memory_game_core #(
    .NUM_COLORS(NC), .MAX_LEVEL(ML), .SHOW_CYCLES(SC),
    .INTRO_FLASHES(IFL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .Go(Go), .LBtn(LBtn), .RBtn(RBtn),
    .Color(Color), .SendColor(SendColor), .Level(Level), .Score(Score),
    .Win(Win), .Lose(Lose)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was last released
  always @(posedge clk) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic g, input logic l, input logic r);
    Go = g; LBtn = l; RBtn = r;
    tick();
    Go = 1'b0; LBtn = 1'b0; RBtn = 1'b0;
  endtask

  // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [NC-1:0] oh(input int c);
    logic [NC-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Pull reset away from a clock edge, check outputs before the next edge
  task automatic do_reset(input logic go_at_release);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_color", Color, 0);
    check("rst_send", SendColor, 0);
    check("rst_level", Level, 0);
    check("rst_score", Score, 0);
    check("rst_win", Win, 0);
    check("rst_lose", Lose, 0);
    repeat (3) tick();
    reset = 1'b1;
    Go = go_at_release;
    tick();
    Go = 1'b0;
    cur = 0;
  endtask

  // Go in IDLE after a random wait; pattern[j] = LFSR after (edges-1+j) steps mod NC
  task automatic start_game(input int wait_n);
    logic [7:0] v;
    repeat (wait_n) tick();
    v = 8'hA5;
    for (int k = 0; k < edges - 1; k++) v = step(v);
    for (int j = 0; j < ML; j++) begin
      pat[j] = int'(v) % NC;
      v = step(v);
    end
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  // Compare the LED stream (fill, optional intro, replay, first INPUT cycle)
  task automatic run_stream(input int lvl, input bit intro, input int limit);
    logic [NC-1:0] q[$];
    if (intro) begin
      repeat (ML) q.push_back('0);
      repeat (IFL) begin
        repeat (SC) q.push_back('1);
        repeat (SC) q.push_back('0);
      end
    end
    for (int e = 0; e < lvl; e++) begin
      repeat (SC) q.push_back(oh(pat[e]));
      repeat (SC / 2) q.push_back('0);
    end
    q.push_back(oh(0));
    for (int i = 0; i < q.size() && i < limit; i++) begin
      if (i > 0) tick();
      check("stream_color", Color, q[i]);
      check("stream_send", SendColor, |q[i]);
    end
    if (limit >= q.size()) begin
      check("show_level", Level, lvl);
      check("show_score", Score, lvl - 1);
      cur = 0;
    end
  endtask

  // Random walk of the cursor towards tgt, checking the one-hot LED each step
  task automatic move_to(input int tgt);
    int act;
    bit last_idle;
    last_idle = 1'b0;
    for (int g = 0; g < 40 && cur != tgt; g++) begin
      act = $urandom_range(0, 3);
      if (act == 3 && last_idle) act = 0;
      case (act)
        0: begin pulse(1'b0, 1'b0, 1'b1); cur = (cur + 1) % NC; end
        1: begin pulse(1'b0, 1'b1, 1'b0); cur = (cur + NC - 1) % NC; end
        2: pulse(1'b0, 1'b1, 1'b1);
        default: tick();
      endcase
      last_idle = (act == 3);
      check("cursor", Color, oh(cur));
    end
    for (int g = 0; g < NC && cur != tgt; g++) begin
      pulse(1'b0, 1'b0, 1'b1);
      cur = (cur + 1) % NC;
      check("cursor", Color, oh(cur));
    end
  endtask

  // Enter the whole sequence for one level correctly
  task automatic play_level(input int lvl);
    for (int e = 0; e < lvl; e++) begin
      move_to(pat[e]);
      pulse(1'b1, 1'b0, 1'b0);
      tick();
      check("no_lose", Lose, 0);
      if (e < lvl - 1) begin
        check("back_to_input", Color, oh(cur));
      end else begin
        check("lvlup_score_old", Score, lvl - 1);
        tick();
        check("lvlup_score_new", Score, lvl);
        if (lvl == ML) begin
          check("win", Win, 1);
          check("win_color", Color, 0);
        end else begin
          run_stream(lvl + 1, 1'b0, 1000);
        end
      end
    end
  endtask

  initial begin
    int wrong;
    // Reset values, and Go on the first edge after release is ignored
    do_reset(1'b1);
    repeat (4) tick();
    check("go_at_release_ignored", Color, 0);

    // Happy path through all levels to WIN
    start_game($urandom_range(3, 20));
    run_stream(1, 1'b1, 1000);
    for (int l = 1; l <= ML; l++) play_level(l);
    pulse(1'b1, 1'b0, 1'b0);
    check("win_cleared", Win, 0);
    check("hold_level", Level, ML);
    check("hold_score", Score, ML);

    // Cursor wrap, simultaneous buttons, then a wrong entry
    start_game($urandom_range(3, 20));
    run_stream(1, 1'b1, 1000);
    pulse(1'b0, 1'b1, 1'b0);
    check("wrap_left", Color, 5'b10000);
    pulse(1'b0, 1'b0, 1'b1);
    check("wrap_right", Color, 5'b00001);
    pulse(1'b0, 1'b1, 1'b1);
    check("both_btns", Color, 5'b00001);
    wrong = (pat[0] + 1 + $urandom_range(0, 3)) % NC;
    move_to(wrong);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    check("wrong_lose", Lose, 1);
    check("wrong_score", Score, 0);
    check("wrong_color", Color, 0);
    pulse(1'b1, 1'b0, 1'b0);
    check("lose_cleared", Lose, 0);

    // Go together with RBtn at cursor 2: colour 2 is the one judged
    for (int t = 0; t < 3; t++) begin
      start_game($urandom_range(3, 20));
      run_stream(1, 1'b1, 1000);
      move_to(2);
      pulse(1'b1, 1'b0, 1'b1);
      tick();
      check("prio_lose", Lose, (pat[0] != 2));
      do_reset(1'b0);
    end

    // Reset in the middle of the replay, then a fresh game
    start_game($urandom_range(3, 20));
    run_stream(1, 1'b1, ML + 2 * SC * IFL + 2);
    check("midshow_level", Level, 1);
    do_reset(1'b0);
    start_game($urandom_range(3, 20));
    run_stream(1, 1'b1, 1000);

`ifdef MEMGAME_TIMEOUT_EN
    repeat (TMO - 1) tick();
    check("tmo_not_yet", Lose, 0);
    tick();
    check("tmo_lose", Lose, 1);
    pulse(1'b1, 1'b0, 1'b0);
    start_game($urandom_range(3, 20));
    run_stream(1, 1'b1, 1000);
    repeat (TMO - 2) tick();
    pulse(1'b0, 1'b1, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_restart_not_yet", Lose, 0);
    tick();
    check("tmo_restart_lose", Lose, 1);
`else
    repeat (30) tick();
    check("no_timeout", Lose, 0);
    check("still_input", Color, oh(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
